// File: rtl/stage_if_fetch_queue_if.sv
// Fetch-stage bus bundle: instruction-memory request/response,
// redirect from execute, and the decode-side handshake.
// Signal prefixes are from the fetch stage's point of view (o_ = driven by fetch).
interface stage_if_fetch_queue_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32
);
  // instruction memory side
  logic                  o_memReq;
  logic [ADDR_WIDTH-1:0] o_memAddr;
  logic                  i_memGnt;
  logic                  i_memRvalid;
  logic [INST_WIDTH-1:0] i_memRdata;
  // redirect from execute
  logic                  i_redirect;
  logic [ADDR_WIDTH-1:0] i_redirectPc;
  // decode side
  logic                  o_valid;
  logic                  i_ready;
  logic [INST_WIDTH-1:0] o_inst;
  logic [ADDR_WIDTH-1:0] o_pc;
  logic                  o_hazard;

  // fetch stage
  modport master (
    output o_memReq, o_memAddr, o_valid, o_inst, o_pc, o_hazard,
    input  i_memGnt, i_memRvalid, i_memRdata, i_redirect, i_redirectPc, i_ready
  );

  // memory / decode / execute environment
  modport slave (
    input  o_memReq, o_memAddr, o_valid, o_inst, o_pc, o_hazard,
    output i_memGnt, i_memRvalid, i_memRdata, i_redirect, i_redirectPc, i_ready
  );
endinterface

// File: rtl/stage_if_fetch_queue.sv
// Instruction-fetch stage with a pipelined memory request port and an
// in-order fetch queue. Requests are credit-limited so that requested plus
// buffered instructions never exceed DEPTH, which guarantees a free queue
// slot for every kept response. A redirect empties the queue and marks every
// still-outstanding response as stale so it is discarded on arrival.
module stage_if_fetch_queue #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input logic                    i_clock,
  input logic                    i_reset,
  stage_if_fetch_queue_if.master fetch_bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0]        DEPTH_SUM = (CNT_W + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP   = ADDR_WIDTH'(INST_WIDTH / 8);

  // control state
  logic [ADDR_WIDTH-1:0] fetch_pc_q,   fetch_pc_d;
  logic [CNT_W-1:0]      count_q,      count_d;
  logic [CNT_W-1:0]      inflight_q,   inflight_d;
  logic [CNT_W-1:0]      drop_q,       drop_d;
  logic [PTR_W-1:0]      rd_ptr_q,     rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q,     wr_ptr_d;
  logic [PTR_W-1:0]      req_rd_ptr_q, req_rd_ptr_d;
  logic [PTR_W-1:0]      req_wr_ptr_q, req_wr_ptr_d;

  // storage: fetch queue entries and PCs of in-flight requests
  logic [ADDR_WIDTH-1:0] fq_pc_q   [DEPTH];
  logic [INST_WIDTH-1:0] fq_inst_q [DEPTH];
  logic [ADDR_WIDTH-1:0] req_pc_q  [DEPTH];

  logic mem_req;
  logic req_fire;
  logic rsp_fire;
  logic rsp_keep;
  logic pop_fire;
  logic head_valid;

  // Request credit counts both buffered and outstanding instructions, stale
  // ones included, since a stale response still occupies the response path.
  assign mem_req  = !i_reset && !fetch_bus.i_redirect &&
                    (({1'b0, count_q} + {1'b0, inflight_q}) < DEPTH_SUM);
  assign req_fire = mem_req && fetch_bus.i_memGnt;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_fire = fetch_bus.i_memRvalid && (inflight_q != '0);
  // Responses landing in a redirect cycle belong to the old stream.
  assign rsp_keep = rsp_fire && (drop_q == '0) && !fetch_bus.i_redirect;

  assign head_valid = (count_q != '0);
  assign pop_fire   = head_valid && fetch_bus.i_ready && !fetch_bus.i_redirect;

  // Next-state computation for PC, counters and pointers.
  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    inflight_d   = inflight_q + CNT_W'(req_fire) - CNT_W'(rsp_fire);
    drop_d       = drop_q;
    count_d      = count_q + CNT_W'(rsp_keep) - CNT_W'(pop_fire);
    rd_ptr_d     = rd_ptr_q + PTR_W'(pop_fire);
    wr_ptr_d     = wr_ptr_q + PTR_W'(rsp_keep);
    req_wr_ptr_d = req_wr_ptr_q + PTR_W'(req_fire);
    req_rd_ptr_d = req_rd_ptr_q + PTR_W'(rsp_fire);

    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
    end

    if (rsp_fire && (drop_q != '0)) begin
      drop_d = drop_q - CNT_W'(1);
    end

    // Every request still outstanding after this cycle is stale, including
    // ones already marked by an earlier redirect (drop is a subset of inflight).
    if (fetch_bus.i_redirect) begin
      fetch_pc_d = fetch_bus.i_redirectPc;
      drop_d     = inflight_d;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end
  end

  // Control registers, cleared asynchronously.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      fetch_pc_q   <= RESET_PC;
      count_q      <= '0;
      inflight_q   <= '0;
      drop_q       <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      req_rd_ptr_q <= '0;
      req_wr_ptr_q <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      count_q      <= count_d;
      inflight_q   <= inflight_d;
      drop_q       <= drop_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      req_rd_ptr_q <= req_rd_ptr_d;
      req_wr_ptr_q <= req_wr_ptr_d;
    end
  end

  // Data storage needs no reset: entries are only visible while counted.
  always_ff @(posedge i_clock) begin
    if (req_fire) begin
      req_pc_q[req_wr_ptr_q] <= fetch_pc_q;
    end
    if (rsp_keep) begin
      fq_pc_q[wr_ptr_q]   <= req_pc_q[req_rd_ptr_q];
      fq_inst_q[wr_ptr_q] <= fetch_bus.i_memRdata;
    end
  end

  assign fetch_bus.o_memReq  = mem_req;
  assign fetch_bus.o_memAddr = fetch_pc_q;
  assign fetch_bus.o_valid   = head_valid;
  assign fetch_bus.o_hazard  = !head_valid;
  // Head is masked to zero when empty so outputs are clean during reset.
  assign fetch_bus.o_inst    = head_valid ? fq_inst_q[rd_ptr_q] : '0;
  assign fetch_bus.o_pc      = head_valid ? fq_pc_q[rd_ptr_q]   : '0;

endmodule
